// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op encodings and op helpers.
package ex_stage_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [3:0] {
        EXE_ADD_OP  = 4'd0,
        EXE_SUB_OP  = 4'd1,
        EXE_SLL_OP  = 4'd2,
        EXE_SLT_OP  = 4'd3,
        EXE_SLTU_OP = 4'd4,
        EXE_XOR_OP  = 4'd5,
        EXE_SRL_OP  = 4'd6,
        EXE_SRA_OP  = 4'd7,
        EXE_OR_OP   = 4'd8,
        EXE_AND_OP  = 4'd9
    } exe_op_e;

    // True for ops whose B operand carries a shift amount in b[24:20].
    function automatic logic exe_is_shift(input logic [3:0] op);
        return (op == EXE_SLL_OP) || (op == EXE_SRL_OP) || (op == EXE_SRA_OP);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass selector: resolves one register operand against three
// younger-to-older result sources; index 0 never takes a bypass.
module fwd_mux #(
    parameter int unsigned XLEN = 32
) (
    input  logic [4:0]      i_idx,
    input  logic [XLEN-1:0] i_val,
    input  logic            i_s2_en,
    input  logic [4:0]      i_s2_rd,
    input  logic [XLEN-1:0] i_s2_val,
    input  logic            i_mem_en,
    input  logic [4:0]      i_mem_rd,
    input  logic [XLEN-1:0] i_mem_val,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_val,
    output logic [XLEN-1:0] o_val
);

    logic w_nz;

    assign w_nz = (i_idx != 5'd0);

    // Priority select: EX/MEM slot first, then memory stage, then writeback.
    always_comb begin
        o_val = i_val;
        if (w_nz && i_s2_en && (i_s2_rd == i_idx)) begin
            o_val = i_s2_val;
        end else if (w_nz && i_mem_en && (i_mem_rd == i_idx)) begin
            o_val = i_mem_val;
        end else if (w_nz && i_wb_en && (i_wb_rd == i_idx)) begin
            o_val = i_wb_val;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX slot (S1) feeding an external ALU, EX/MEM slot (S2)
// capturing its result, with operand bypass and valid/ready flow control.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [3:0]      id_op,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_a_pc,
    input  logic            id_b_imm,
    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_val,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_val,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_y,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_result,
    output logic [4:0]      ex_rd
);

    // S1 (ID/EX) contents
    logic            r_s1_valid;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic            r_a_pc;
    logic            r_b_imm;

    // S2 (EX/MEM) contents
    logic            r_s2_valid;
    logic [XLEN-1:0] r_ex_result;
    logic [4:0]      r_ex_rd;

    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_s1_hold;
    logic            w_capture;
    logic [XLEN-1:0] w_rs1_res;
    logic [XLEN-1:0] w_rs2_res;
    logic [4:0]      w_shamt;

    assign w_s2_adv  = !r_s2_valid || ex_ready;
    // A flushed S1 entry is killed, so it must not move into S2 either.
    assign w_s1_adv  = r_s1_valid && w_s2_adv && !flush;
    assign w_s1_hold = r_s1_valid && !w_s2_adv;
    assign id_ready  = !flush && (!r_s1_valid || w_s2_adv);
    assign w_capture = id_valid && id_ready;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_idx     (r_rs1),
        .i_val     (r_rs1_val),
        .i_s2_en   (r_s2_valid),
        .i_s2_rd   (r_ex_rd),
        .i_s2_val  (r_ex_result),
        .i_mem_en  (mem_fwd_en),
        .i_mem_rd  (mem_fwd_rd),
        .i_mem_val (mem_fwd_val),
        .i_wb_en   (wb_fwd_en),
        .i_wb_rd   (wb_fwd_rd),
        .i_wb_val  (wb_fwd_val),
        .o_val     (w_rs1_res)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_idx     (r_rs2),
        .i_val     (r_rs2_val),
        .i_s2_en   (r_s2_valid),
        .i_s2_rd   (r_ex_rd),
        .i_s2_val  (r_ex_result),
        .i_mem_en  (mem_fwd_en),
        .i_mem_rd  (mem_fwd_rd),
        .i_mem_val (mem_fwd_val),
        .i_wb_en   (wb_fwd_en),
        .i_wb_rd   (wb_fwd_rd),
        .i_wb_val  (wb_fwd_val),
        .o_val     (w_rs2_res)
    );

    assign w_shamt = r_b_imm ? r_imm[4:0] : w_rs2_res[4:0];

    // S1 register: capture from decode, drain on advance/flush, and refresh
    // operands with resolved values while stalled so late bypasses stick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_op       <= '0;
            r_pc       <= '0;
            r_rs1_val  <= '0;
            r_rs2_val  <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_a_pc     <= 1'b0;
            r_b_imm    <= 1'b0;
        end else if (w_capture) begin
            r_s1_valid <= 1'b1;
            r_op       <= id_op;
            r_pc       <= id_pc;
            r_rs1_val  <= id_rs1_val;
            r_rs2_val  <= id_rs2_val;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_a_pc     <= id_a_pc;
            r_b_imm    <= id_b_imm;
        end else begin
            if (flush || w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s1_hold) begin
                r_rs1_val <= w_rs1_res;
                r_rs2_val <= w_rs2_res;
            end
        end
    end

    // ALU drive: idle S1 presents ADD 0,0 so the ALU result is always defined.
    always_comb begin
        alu_op = EXE_ADD_OP;
        alu_a  = '0;
        alu_b  = '0;
        if (r_s1_valid) begin
            alu_op = r_op;
            alu_a  = r_a_pc ? r_pc : w_rs1_res;
            if (exe_is_shift(r_op)) begin
                alu_b = {7'b0, w_shamt, 20'b0};
            end else begin
                alu_b = r_b_imm ? r_imm : w_rs2_res;
            end
        end
    end

    // S2 register: load ALU result on S1 advance, drain when memory accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            r_ex_result <= '0;
            r_ex_rd     <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid  <= 1'b1;
            r_ex_result <= alu_y;
            r_ex_rd     <= r_rd;
        end else if (ex_ready) begin
            r_s2_valid  <= 1'b0;
        end
    end

    assign ex_valid  = r_s2_valid;
    assign ex_result = r_ex_result;
    assign ex_rd     = r_ex_rd;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a behavioural ALU standing in for the parent.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [3:0]  id_op;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_a_pc, id_b_imm;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_val, wb_fwd_val;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_val(mem_fwd_val),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_val(wb_fwd_val),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_result(ex_result), .ex_rd(ex_rd)
    );

    // Reference ALU: shift amount taken from b[24:20].
    always_comb begin
        alu_y = '0;
        case (alu_op)
            EXE_ADD_OP:  alu_y = alu_a + alu_b;
            EXE_SUB_OP:  alu_y = alu_a - alu_b;
            EXE_SLL_OP:  alu_y = alu_a << alu_b[24:20];
            EXE_SRL_OP:  alu_y = alu_a >> alu_b[24:20];
            EXE_SRA_OP:  alu_y = $signed(alu_a) >>> alu_b[24:20];
            EXE_SLT_OP:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            EXE_SLTU_OP: alu_y = {31'b0, alu_a < alu_b};
            EXE_XOR_OP:  alu_y = alu_a ^ alu_b;
            EXE_OR_OP:   alu_y = alu_a | alu_b;
            EXE_AND_OP:  alu_y = alu_a & alu_b;
            default:     alu_y = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] r1v, input logic [31:0] r2v,
                        input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic bimm);
        id_valid   = 1'b1;
        id_op      = op;
        id_pc      = 32'h0000_1000;
        id_rs1_val = r1v;
        id_rs2_val = r2v;
        id_imm     = imm;
        id_rs1     = r1;
        id_rs2     = r2;
        id_rd      = rd;
        id_a_pc    = 1'b0;
        id_b_imm   = bimm;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; id_valid = 1'b0; id_op = '0;
        id_pc = '0; id_rs1_val = '0; id_rs2_val = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_a_pc = 1'b0; id_b_imm = 1'b0;
        mem_fwd_en = 1'b0; mem_fwd_rd = '0; mem_fwd_val = '0;
        wb_fwd_en = 1'b0; wb_fwd_rd = '0; wb_fwd_val = '0;
        ex_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_result", ex_result, 32'd0);
        chk("rst_id_ready", {31'b0, id_ready}, 32'd1);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);

        // ADD with independent operands
        send(EXE_ADD_OP, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd6, 1'b0);
        step();
        id_valid = 1'b0;
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_lat_valid0", {31'b0, ex_valid}, 32'd0);
        step();
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_result", ex_result, 32'd12);
        chk("add_rd", {27'b0, ex_rd}, 32'd6);
        step();
        chk("add_drain", {31'b0, ex_valid}, 32'd0);

        // Back-to-back dependency via S2 bypass
        send(EXE_ADD_OP, 32'd10, 32'd0, 32'd1, 5'd1, 5'd0, 5'd3, 1'b1);
        step();
        send(EXE_SUB_OP, 32'd0, 32'd4, 32'd0, 5'd3, 5'd4, 5'd7, 1'b0);
        step();
        id_valid = 1'b0;
        chk("dep_first", ex_result, 32'd11);
        chk("dep_fwd_a", alu_a, 32'd11);
        step();
        chk("dep_second", ex_result, 32'd7);
        chk("dep_second_rd", {27'b0, ex_rd}, 32'd7);
        step();

        // Bypass retained across a stall
        ex_ready = 1'b0;
        send(EXE_ADD_OP, 32'd2, 32'd3, 32'd0, 5'd0, 5'd0, 5'd9, 1'b0);
        step();
        send(EXE_ADD_OP, 32'd0, 32'd1, 32'd0, 5'd5, 5'd0, 5'd10, 1'b0);
        step();
        id_valid = 1'b0;
        chk("bp_id_ready", {31'b0, id_ready}, 32'd0);
        chk("bp_s2_result", ex_result, 32'd5);
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_val = 32'h99;
        #1;
        chk("stall_wb_fwd", alu_a, 32'h99);
        step();
        wb_fwd_en = 1'b0;
        #1;
        chk("stall_retained", alu_a, 32'h99);
        chk("stall_stable", ex_result, 32'd5);
        ex_ready = 1'b1;
        step();
        chk("stall_result", ex_result, 32'h9A);
        chk("stall_rd", {27'b0, ex_rd}, 32'd10);
        step();

        // Shift operand formatting
        send(EXE_SRA_OP, 32'h8000_0000, 32'h23, 32'd0, 5'd1, 5'd2, 5'd11, 1'b0);
        step();
        send(EXE_SLL_OP, 32'd1, 32'd0, 32'd4, 5'd1, 5'd0, 5'd12, 1'b1);
        chk("sra_alu_b", alu_b, 32'h0030_0000);
        chk("sra_alu_op", {28'b0, alu_op}, 32'd7);
        step();
        id_valid = 1'b0;
        chk("sra_result", ex_result, 32'hF000_0000);
        chk("slli_alu_b", alu_b, 32'h0040_0000);
        step();
        chk("slli_result", ex_result, 32'h10);
        step();

        // Flush with both slots full and a new instruction offered
        ex_ready = 1'b0;
        send(EXE_ADD_OP, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 5'd12, 1'b0);
        step();
        send(EXE_ADD_OP, 32'd3, 32'd4, 32'd0, 5'd0, 5'd0, 5'd13, 1'b0);
        step();
        send(EXE_ADD_OP, 32'd100, 32'd1, 32'd0, 5'd0, 5'd0, 5'd14, 1'b0);
        flush = 1'b1;
        ex_ready = 1'b1;
        #1;
        chk("flush_id_ready", {31'b0, id_ready}, 32'd0);
        chk("flush_s2_valid", {31'b0, ex_valid}, 32'd1);
        chk("flush_s2_result", ex_result, 32'd3);
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        #1;
        chk("flush_dropped", {31'b0, ex_valid}, 32'd0);
        chk("flush_id_ready_after", {31'b0, id_ready}, 32'd1);
        chk("flush_s1_empty", alu_a, 32'd0);
        step();
        chk("flush_not_accepted", {31'b0, ex_valid}, 32'd0);

        // Reset while stalled with both slots full
        ex_ready = 1'b0;
        send(EXE_ADD_OP, 32'd1, 32'd1, 32'd0, 5'd0, 5'd0, 5'd15, 1'b0);
        step();
        send(EXE_ADD_OP, 32'd2, 32'd2, 32'd0, 5'd0, 5'd0, 5'd16, 1'b0);
        step();
        id_valid = 1'b0;
        chk("pre_rst_full", {31'b0, ex_valid}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("mid_rst_result", ex_result, 32'd0);
        chk("mid_rst_rd", {27'b0, ex_rd}, 32'd0);
        chk("mid_rst_id_ready", {31'b0, id_ready}, 32'd1);

        // x0 never forwards; memory bypass outranks writeback
        ex_ready = 1'b1;
        mem_fwd_en = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_val = 32'hFF;
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_val = 32'hEE;
        send(EXE_ADD_OP, 32'd5, 32'd6, 32'd0, 5'd0, 5'd0, 5'd17, 1'b0);
        step();
        chk("x0_alu_a", alu_a, 32'd5);
        chk("x0_alu_b", alu_b, 32'd6);
        send(EXE_ADD_OP, 32'd5, 32'd0, 32'd0, 5'd0, 5'd6, 5'd18, 1'b0);
        mem_fwd_rd = 5'd6; mem_fwd_val = 32'h10;
        wb_fwd_rd = 5'd6; wb_fwd_val = 32'h20;
        step();
        id_valid = 1'b0;
        chk("x0_result", ex_result, 32'd11);
        chk("prio_alu_b", alu_b, 32'h10);
        step();
        chk("prio_result", ex_result, 32'h15);
        mem_fwd_en = 1'b0;
        wb_fwd_en = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
